miriscv_fetch_buffer: RTL
=========================

MIRISCV_FETCH_BUFFER -- requirements
Module: miriscv_fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width; only 32 is supported.
REQ-003 SHALL have parameter RV32C, default 1, enabling 16-bit compressed instruction extraction.
REQ-004 SHALL have parameter DEPTH, default 4, word-FIFO depth; power of two, at least 2.
REQ-005 SHALL have parameter RESET_PC, default 32'h8000_0000, PC after reset.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL provide the following ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  discard buffered words and redirect.
- flush_pc_i  input  XLEN  redirect target.
- fetch_valid_i  input  1  fetched word valid.
- fetch_ready_o  output  1  buffer can accept a word.
- fetch_data_i  input  32  fetched word; words arrive in ascending word-address order.
- instr_valid_o  output  1  complete instruction available.
- instr_ready_i  input  1  consumer takes instruction.
- instr_o  output  ILEN  instruction; compressed ones are zero-extended in [15:0].
- instr_pc_o  output  XLEN  PC of instr_o.
- instr_compressed_o  output  1  instr_o is 16-bit.

Function
REQ-008 SHALL hold up to DEPTH 32-bit words in a circular FIFO (head/tail pointers wrapping modulo DEPTH, count of width clog2(DEPTH)+1), plus a current PC and a halfword offset bit (off).
REQ-009 SHALL accept a word on fetch_valid_i && fetch_ready_o; fetch_ready_o SHALL equal (count < DEPTH) from registered state, with no combinational path from instr_ready_i.
REQ-010 SHALL decode the current instruction combinationally from head word H, next word N, off and count:
- off=0, H[1:0]=11: 32-bit, valid if count>=1, instr_o=H.
- off=0, H[1:0]!=11: compressed, valid if count>=1, instr_o={16'h0,H[15:0]}.
- off=1, H[17:16]=11: 32-bit, valid if count>=2, instr_o={N[15:0],H[31:16]}.
- off=1, H[17:16]!=11: compressed, valid if count>=1, instr_o={16'h0,H[31:16]}.
REQ-011 SHALL, with RV32C=0, hold off at 0, treat every instruction as 32-bit, and drive instr_compressed_o=0.
REQ-012 SHALL, on instr_valid_o && instr_ready_i, update state as follows:
- 32-bit, off=0: pop 1 word.
- compressed, off=0: off to 1, no pop.
- compressed, off=1: pop 1 word, off to 0.
- 32-bit, off=1: pop 1 word, off stays 1.
- PC advances by 4 for 32-bit instructions and by 2 for compressed, modulo 2^XLEN.
REQ-013 SHALL support push and pop in the same cycle, with count changing by the net amount.
REQ-014 SHALL, on flush_i, set count to 0 and reset the pointers, PC to flush_pc_i, and off to flush_pc_i[1] (0 if RV32C=0).
REQ-015 SHALL, during a flush cycle, ignore the fetch handshake and pop for that cycle, and force instr_valid_o=0 combinationally.
REQ-016 SHALL give flush_i priority over push and pop in the same cycle.
REQ-017 SHALL give a latency of one cycle from the accepting fetch edge to instr_valid_o, or from the second word's edge for a straddling instruction.
REQ-018 SHALL hold instr_o, instr_pc_o and instr_compressed_o stable while instr_valid_o=1 and instr_ready_i=0, absent a flush.
REQ-019 SHALL ignore flush_pc_i[0].

Reset
REQ-020 SHALL, when rst_i is high at a clock edge, set count=0, head=tail=0, PC=RESET_PC and off=RESET_PC[1]&RV32C.
REQ-021 SHALL, after reset, drive fetch_ready_o=1 and instr_valid_o=0.
REQ-022 SHALL give reset priority over flush and all handshakes, including reset asserted mid-operation with a full buffer.

Verification
REQ-023 SHALL pass: reset, push 0x00A00093 -> next cycle instr_valid_o=1, instr_o=0x00A00093, instr_pc_o=0x80000000, instr_compressed_o=0; ready=1 pops it, so count=0.
REQ-024 SHALL pass: push 0x45054501, ready held 1 -> 0x00004501 @0x80000000 then 0x00004505 @0x80000002, both compressed; exactly one word popped after the second.
REQ-025 SHALL pass: flush to 0x80000002, push 0x00930000 -> instr_valid_o=0; then push 0x000000A0 -> instr_o=0x00A00093 @0x80000002, 32-bit; pop leaves off=1, PC=0x80000006.
REQ-026 SHALL pass: DEPTH=4, ready=0, fetch_valid_i held for 5 words -> fetch_ready_o=0 after 4th acceptance, 5th not taken; one pop -> fetch_ready_o=1 next cycle.
REQ-027 SHALL pass: buffer holding 3 words, flush_i with flush_pc_i=0x80000100 and simultaneous fetch_valid_i and instr_ready_i -> instr_valid_o=0 that cycle, count=0 after, next instr_pc_o=0x80000100.
REQ-028 SHALL pass: rst_i asserted with full buffer and valid output -> next cycle count=0, fetch_ready_o=1, instr_valid_o=0, PC=0x80000000.

Source files
------------

// File: rtl/miriscv_fetch_buffer.sv
// Instruction fetch buffer: queues fetched 32-bit words and carves them into
// 16-bit compressed or 32-bit instructions, including ones straddling two words.
module miriscv_fetch_buffer #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              RV32C    = 1,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic [31:0]     fetch_data_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [ILEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_compressed_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic COMP_EN = (RV32C != 0);

   logic [31:0]     memQ [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            off_q, off_d;

   logic [31:0]     headWord;
   logic [15:0]     nextLow;
   logic [XLEN-1:0] flushPc;
   logic            isComp, instrValid, pushEn, popFire, popWord;
   logic [ILEN-1:0] instr;

   assign headWord = memQ[head_q];
   assign nextLow  = memQ[head_q + PW'(1)][15:0];
   assign flushPc  = flush_pc_i & ~XLEN'(1);

   assign fetch_ready_o = (count_q < CW'(DEPTH));

   // Decode the instruction at the head; a 32-bit one at offset 1 needs the next word too.
   always_comb begin
      isComp     = 1'b0;
      instrValid = 1'b0;
      instr      = headWord;
      if (!COMP_EN || !off_q) begin
         isComp     = COMP_EN && (headWord[1:0] != 2'b11);
         instrValid = (count_q != '0);
         instr      = isComp ? {16'h0000, headWord[15:0]} : headWord;
      end else begin
         isComp     = (headWord[17:16] != 2'b11);
         instrValid = isComp ? (count_q != '0) : (count_q >= CW'(2));
         instr      = isComp ? {16'h0000, headWord[31:16]} : {nextLow, headWord[31:16]};
      end
      if (flush_i) begin
         instrValid = 1'b0;
      end
   end

   assign instr_valid_o      = instrValid;
   assign instr_o            = instr;
   assign instr_pc_o         = pc_q;
   assign instr_compressed_o = isComp;

   assign pushEn  = fetch_valid_i && fetch_ready_o && !flush_i;
   assign popFire = instrValid && instr_ready_i;
   // A word is retired unless a compressed instruction only consumed its low half.
   assign popWord = popFire && (!isComp || off_q);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pc_d    = pc_q;
      off_d   = off_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         pc_d    = flushPc;
         off_d   = flush_pc_i[1] && COMP_EN;
      end else begin
         if (pushEn) begin
            tail_d = tail_q + PW'(1);
         end
         if (popWord) begin
            head_d = head_q + PW'(1);
         end
         count_d = count_q + CW'(pushEn) - CW'(popWord);
         if (popFire) begin
            pc_d = pc_q + (isComp ? XLEN'(2) : XLEN'(4));
            if (isComp) begin
               off_d = !off_q;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pc_q    <= RESET_PC;
         off_q   <= RESET_PC[1] && COMP_EN;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         off_q   <= off_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushEn && !rst_i) begin
         memQ[tail_q] <= fetch_data_i;
      end
   end

endmodule
